// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master bus arbiter.
// Holds the FSM state encoding, master index type, wait counter width and idle bus values.
package bus_arb_pkg;
   localparam int WAIT_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      ACK     = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   typedef logic master_idx_t;

   localparam logic        IDLE_AS_L = 1'b1;
   localparam logic        IDLE_WE_L = 1'b1;
   localparam logic [31:0] IDLE_ADDR = 32'h0000_0000;
   localparam logic [3:0]  IDLE_BE   = 4'h0;
   localparam logic [31:0] IDLE_DATA = 32'h0000_0000;
endpackage

// File: rtl/bus_arbiter_wait_state_counter.sv
// Wait-state down counter: load, saturating decrement and zero flag.
module wait_state_counter
   import bus_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [WAIT_W-1:0] load_val,
   input  logic              dec,
   output logic              zero
);

   logic [WAIT_W-1:0] cnt_q;
   logic [WAIT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with per-region wait-state DTAck generation.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise M0 has fixed priority.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int unsigned FAST_WAIT = 1,
   parameter int unsigned SLOW_WAIT = 3
) (
   input  logic        Clock,
   input  logic        Reset_L,
   input  logic        M0_AS_L,
   input  logic        M1_AS_L,
   input  logic        M0_WE_L,
   input  logic        M1_WE_L,
   input  logic [31:0] M0_Address,
   input  logic [31:0] M1_Address,
   input  logic [3:0]  M0_ByteEnable,
   input  logic [3:0]  M1_ByteEnable,
   input  logic [31:0] M0_DataOut,
   input  logic [31:0] M1_DataOut,
   output logic        M0_DTAck,
   output logic        M1_DTAck,
   output logic        M0_Grant,
   output logic        M1_Grant,
   input  logic        Slow_Select_H,
   output logic        AS_L,
   output logic        WE_L,
   output logic [31:0] Address,
   output logic [3:0]  ByteEnable,
   output logic [31:0] DataOut,
   output logic [1:0]  dbg_state
);

   localparam logic [WAIT_W-1:0] FAST_W = WAIT_W'(FAST_WAIT);
   localparam logic [WAIT_W-1:0] SLOW_W = WAIT_W'(SLOW_WAIT);

   arb_state_t  state_q, state_d;
   logic        grant_vld_q, grant_vld_d;
   master_idx_t grant_idx_q, grant_idx_d;
   logic        first_q, first_d;
   logic        cnt_load, cnt_dec, cnt_zero;
   logic [WAIT_W-1:0] wait_sel;
   master_idx_t win_idx;
   logic        req0, req1, gnt_as_l, bus_on;

   assign req0     = ~M0_AS_L;
   assign req1     = ~M1_AS_L;
   assign gnt_as_l = grant_idx_q ? M1_AS_L : M0_AS_L;
   assign wait_sel = Slow_Select_H ? SLOW_W : FAST_W;

`ifdef BUS_ARB_ROUND_ROBIN_EN
   master_idx_t ptr_q, ptr_d;
   // On contention the pointer names the master that was not served last.
   assign win_idx = (req0 && req1) ? ptr_q : req1;
`else
   assign win_idx = req0 ? 1'b0 : 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      grant_vld_d = grant_vld_q;
      grant_idx_d = grant_idx_q;
      first_d     = 1'b0;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      ptr_d       = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               state_d     = GRANT;
               grant_vld_d = 1'b1;
               grant_idx_d = win_idx;
               first_d     = 1'b1;
            end
         end
         GRANT: begin
            // Abort wins over the wait count, so an aborted cycle never acks.
            if (gnt_as_l) begin
               state_d = RELEASE;
`ifdef BUS_ARB_ROUND_ROBIN_EN
               ptr_d   = ~grant_idx_q;
`endif
            end else if (first_q) begin
               if (wait_sel == '0) begin
                  state_d = ACK;
               end else begin
                  cnt_load = 1'b1;
               end
            end else if (cnt_zero) begin
               state_d = ACK;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ACK: begin
            state_d = RELEASE;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            ptr_d   = ~grant_idx_q;
`endif
         end
         RELEASE: begin
            if (gnt_as_l) begin
               state_d     = IDLE;
               grant_vld_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            grant_vld_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         state_q     <= IDLE;
         grant_vld_q <= 1'b0;
         grant_idx_q <= 1'b0;
         first_q     <= 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
         ptr_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         grant_vld_q <= grant_vld_d;
         grant_idx_q <= grant_idx_d;
         first_q     <= first_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
         ptr_q       <= ptr_d;
`endif
      end
   end

   // The first GRANT cycle decides the wait itself, so the counter holds W-1.
   wait_state_counter u_wait (
      .clk      (Clock),
      .rst_n    (Reset_L),
      .load     (cnt_load),
      .load_val (wait_sel - 1'b1),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   assign bus_on = grant_vld_q && ((state_q == GRANT) || (state_q == ACK));

   always_comb begin
      AS_L       = IDLE_AS_L;
      WE_L       = IDLE_WE_L;
      Address    = IDLE_ADDR;
      ByteEnable = IDLE_BE;
      DataOut    = IDLE_DATA;
      if (bus_on) begin
         AS_L       = 1'b0;
         WE_L       = grant_idx_q ? M1_WE_L       : M0_WE_L;
         Address    = grant_idx_q ? M1_Address    : M0_Address;
         ByteEnable = grant_idx_q ? M1_ByteEnable : M0_ByteEnable;
         DataOut    = grant_idx_q ? M1_DataOut    : M0_DataOut;
      end
   end

   assign M0_Grant  = grant_vld_q & ~grant_idx_q;
   assign M1_Grant  = grant_vld_q &  grant_idx_q;
   assign M0_DTAck  = (state_q == ACK) & M0_Grant;
   assign M1_DTAck  = (state_q == ACK) & M1_Grant;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter: reset, fast read, slow write, contention, abort, reset mid-transfer.
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset_L = 1'b0;
  logic        M0_AS_L = 1'b1, M1_AS_L = 1'b1;
  logic        M0_WE_L = 1'b1, M1_WE_L = 1'b1;
  logic [31:0] M0_Address = '0, M1_Address = '0;
  logic [3:0]  M0_ByteEnable = '0, M1_ByteEnable = '0;
  logic [31:0] M0_DataOut = '0, M1_DataOut = '0;
  logic        Slow_Select_H = 1'b0;
  logic        M0_DTAck, M1_DTAck, M0_Grant, M1_Grant;
  logic        AS_L, WE_L;
  logic [31:0] Address, DataOut;
  logic [3:0]  ByteEnable;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  bus_arbiter #(.FAST_WAIT(1), .SLOW_WAIT(3)) dut (
    .Clock(Clock), .Reset_L(Reset_L),
    .M0_AS_L(M0_AS_L), .M1_AS_L(M1_AS_L),
    .M0_WE_L(M0_WE_L), .M1_WE_L(M1_WE_L),
    .M0_Address(M0_Address), .M1_Address(M1_Address),
    .M0_ByteEnable(M0_ByteEnable), .M1_ByteEnable(M1_ByteEnable),
    .M0_DataOut(M0_DataOut), .M1_DataOut(M1_DataOut),
    .M0_DTAck(M0_DTAck), .M1_DTAck(M1_DTAck),
    .M0_Grant(M0_Grant), .M1_Grant(M1_Grant),
    .Slow_Select_H(Slow_Select_H),
    .AS_L(AS_L), .WE_L(WE_L), .Address(Address),
    .ByteEnable(ByteEnable), .DataOut(DataOut),
    .dbg_state(dbg_state)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Both masters low on entry, state IDLE; serve one transfer with W=1.
  task automatic contend_once(input string tag, input logic exp_m1);
    tick();
    chk({tag, "_m0_grant"}, {31'b0, M0_Grant}, {31'b0, ~exp_m1});
    chk({tag, "_m1_grant"}, {31'b0, M1_Grant}, {31'b0, exp_m1});
    tick();
    tick();
    chk({tag, "_dtack"}, {30'b0, M1_DTAck, M0_DTAck}, exp_m1 ? 32'h2 : 32'h1);
    if (exp_m1) M1_AS_L = 1'b1; else M0_AS_L = 1'b1;
    tick();
    chk({tag, "_release"}, {30'b0, dbg_state}, 32'(RELEASE));
    tick();
    chk({tag, "_idle"}, {30'b0, M1_Grant, M0_Grant}, 32'h0);
    M0_AS_L = 1'b0;
    M1_AS_L = 1'b0;
  endtask

  initial begin
    // Reset idle with both requests asserted
    M0_AS_L = 1'b0;
    M1_AS_L = 1'b0;
    repeat (2) tick();
    chk("rst_as_l", {31'b0, AS_L}, 32'h1);
    chk("rst_we_l", {31'b0, WE_L}, 32'h1);
    chk("rst_addr", Address, 32'h0);
    chk("rst_grants", {30'b0, M1_Grant, M0_Grant}, 32'h0);
    chk("rst_dtacks", {30'b0, M1_DTAck, M0_DTAck}, 32'h0);
    chk("rst_state", {30'b0, dbg_state}, 32'(IDLE));
    Reset_L = 1'b1;
    tick();
    chk("rst_rel_grant", {30'b0, M1_Grant, M0_Grant}, 32'h1);
    chk("rst_rel_as_l", {31'b0, AS_L}, 32'h0);
    // Drop both requests: M0 aborts out of its first GRANT cycle
    M0_AS_L = 1'b1;
    M1_AS_L = 1'b1;
    tick();
    chk("rst_abort_rel", {30'b0, dbg_state}, 32'(RELEASE));
    tick();
    chk("rst_abort_idle", {30'b0, dbg_state}, 32'(IDLE));

    // Fast read by M0, W=1
    M0_Address = 32'h0001_0000;
    M0_WE_L = 1'b1;
    M0_ByteEnable = 4'hF;
    M0_DataOut = 32'hDEAD_BEEF;
    Slow_Select_H = 1'b0;
    M0_AS_L = 1'b0;
    tick();
    chk("fr_g1_as_l", {31'b0, AS_L}, 32'h0);
    chk("fr_g1_addr", Address, 32'h0001_0000);
    chk("fr_g1_grant", {30'b0, M1_Grant, M0_Grant}, 32'h1);
    chk("fr_g1_dtack", {31'b0, M0_DTAck}, 32'h0);
    tick();
    chk("fr_g2_as_l", {31'b0, AS_L}, 32'h0);
    chk("fr_g2_dtack", {31'b0, M0_DTAck}, 32'h0);
    tick();
    chk("fr_ack_dtack", {31'b0, M0_DTAck}, 32'h1);
    chk("fr_ack_m1dt", {31'b0, M1_DTAck}, 32'h0);
    chk("fr_ack_as_l", {31'b0, AS_L}, 32'h0);
    chk("fr_ack_we_l", {31'b0, WE_L}, 32'h1);
    M0_AS_L = 1'b1;
    tick();
    chk("fr_rel_as_l", {31'b0, AS_L}, 32'h1);
    chk("fr_rel_dtack", {31'b0, M0_DTAck}, 32'h0);
    chk("fr_rel_addr", Address, 32'h0);
    tick();
    chk("fr_idle_grant", {30'b0, M1_Grant, M0_Grant}, 32'h0);

    // Slow write by M1, W=3; decoder flag drops after sampling
    M1_Address = 32'h0002_0000;
    M1_WE_L = 1'b0;
    M1_ByteEnable = 4'b0001;
    M1_DataOut = 32'h0000_00FF;
    Slow_Select_H = 1'b1;
    M1_AS_L = 1'b0;
    tick();
    chk("sw_g1_grant", {30'b0, M1_Grant, M0_Grant}, 32'h2);
    chk("sw_g1_addr", Address, 32'h0002_0000);
    chk("sw_g1_we_l", {31'b0, WE_L}, 32'h0);
    chk("sw_g1_be", {28'b0, ByteEnable}, 32'h1);
    chk("sw_g1_data", DataOut, 32'h0000_00FF);
    tick();
    Slow_Select_H = 1'b0;
    chk("sw_g2_dtack", {30'b0, M1_DTAck, M0_DTAck}, 32'h0);
    tick();
    chk("sw_g3_dtack", {30'b0, M1_DTAck, M0_DTAck}, 32'h0);
    tick();
    chk("sw_g4_dtack", {30'b0, M1_DTAck, M0_DTAck}, 32'h0);
    tick();
    chk("sw_ack_dtack", {30'b0, M1_DTAck, M0_DTAck}, 32'h2);
    chk("sw_ack_data", DataOut, 32'h0000_00FF);
    M1_AS_L = 1'b1;
    tick();
    chk("sw_rel_dtack", {30'b0, M1_DTAck, M0_DTAck}, 32'h0);
    chk("sw_rel_we_l", {31'b0, WE_L}, 32'h1);
    tick();
    chk("sw_idle_state", {30'b0, dbg_state}, 32'(IDLE));

    // Contention: last served was M1
    M0_AS_L = 1'b0;
    M1_AS_L = 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    contend_once("ct0", 1'b0);
    contend_once("ct1", 1'b1);
    contend_once("ct2", 1'b0);
`else
    contend_once("ct0", 1'b0);
    contend_once("ct1", 1'b0);
    contend_once("ct2", 1'b0);
`endif
    M0_AS_L = 1'b1;
    M1_AS_L = 1'b1;
    tick();
    tick();
    chk("ct_end_state", {30'b0, dbg_state}, 32'(IDLE));

    // Abort: M0 raises AS_L in its second GRANT cycle
    M0_AS_L = 1'b0;
    tick();
    tick();
    chk("ab_g2_state", {30'b0, dbg_state}, 32'(GRANT));
    M0_AS_L = 1'b1;
    tick();
    chk("ab_rel_state", {30'b0, dbg_state}, 32'(RELEASE));
    chk("ab_rel_dtack", {30'b0, M1_DTAck, M0_DTAck}, 32'h0);
    chk("ab_rel_as_l", {31'b0, AS_L}, 32'h1);
    tick();
    chk("ab_idle_state", {30'b0, dbg_state}, 32'(IDLE));
    chk("ab_idle_grant", {30'b0, M1_Grant, M0_Grant}, 32'h0);
    chk("ab_idle_dtack", {30'b0, M1_DTAck, M0_DTAck}, 32'h0);

    // Reset mid-transfer drops the bus asynchronously
    M1_AS_L = 1'b0;
    tick();
    chk("rm_grant", {30'b0, M1_Grant, M0_Grant}, 32'h2);
    #1;
    Reset_L = 1'b0;
    #1;
    chk("rm_as_l", {31'b0, AS_L}, 32'h1);
    chk("rm_grants", {30'b0, M1_Grant, M0_Grant}, 32'h0);
    M1_AS_L = 1'b1;
    tick();
    Reset_L = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rm_no_dtack", {30'b0, M1_DTAck, M0_DTAck}, 32'h0);
    end
    chk("rm_state", {30'b0, dbg_state}, 32'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
